// File: rtl/apb2_pkg.sv
// Shared APB2 definitions: FSM state encoding and the PSEL/PENABLE phase
// pattern that belongs to each state.
package apb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic psel;
    logic penable;
  } apb_phase_t;

  localparam apb_phase_t PHASE_IDLE   = 2'b00;
  localparam apb_phase_t PHASE_SETUP  = 2'b10;
  localparam apb_phase_t PHASE_ACCESS = 2'b11;

  function automatic apb_phase_t phase_of(input apb_state_e s);
    case (s)
      ST_SETUP:  return PHASE_SETUP;
      ST_ACCESS: return PHASE_ACCESS;
      default:   return PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/apb2_master_arbiter_if.sv
// APB2 bus bundle between the arbitrating master and a single slave.
interface apb2_master_arbiter_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
);
  logic [ADDR_BITS-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DATA_BITS-1:0] PWDATA;
  logic [DATA_BITS-1:0] PRDATA;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on contention the requester not granted last
// wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic gnt_idx_o,
  output logic gnt_vld_o
);

  always_comb begin
    gnt_vld_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      gnt_idx_o = ~last_i;
    end else begin
      gnt_idx_o = valid1_i;
    end
  end

endmodule

// File: rtl/apb2_master_arbiter.sv
// APB2 master shared by two requesters: round-robin acceptance in IDLE or
// ACCESS, fixed SETUP->ACCESS sequence, registered per-requester completion.
module apb2_master_arbiter
  import apb2_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,

  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BITS-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic                 req0_done,
  output logic [DATA_BITS-1:0] req0_rdata,

  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BITS-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 req1_done,
  output logic [DATA_BITS-1:0] req1_rdata,

  apb2_master_arbiter_if.master apb
);

  apb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q;
  logic [ADDR_BITS-1:0] paddr_q;
  logic                 pwrite_q;
  logic [DATA_BITS-1:0] pwdata_q;
  logic [1:0]           done_q, done_d;
  logic [DATA_BITS-1:0] rdata0_q, rdata1_q;

  logic       gnt_idx, gnt_vld;
  logic       accept;
  apb_phase_t phase;

  rr_arbiter2 u_rr (
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .last_i    (last_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Acceptance is blocked during SETUP and while reset is held.
  assign accept = gnt_vld && (state_q != ST_SETUP) && PRESETn;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = accept ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = accept ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase      = phase_of(state_q);
    req0_ready = accept && !gnt_idx;
    req1_ready = accept &&  gnt_idx;
    last_d     = accept ? gnt_idx : last_q;
    done_d     = 2'b00;
    if (state_q == ST_ACCESS) begin
      done_d = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Transfer attributes are latched on acceptance and held through IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      last_q <= last_d;
      if (accept) begin
        owner_q  <= gnt_idx;
        paddr_q  <= gnt_idx ? req1_addr  : req0_addr;
        pwrite_q <= gnt_idx ? req1_write : req0_write;
        pwdata_q <= gnt_idx ? req1_wdata : req0_wdata;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      done_q <= done_d;
      if (state_q == ST_ACCESS && !pwrite_q) begin
        if (owner_q) begin
          rdata1_q <= apb.PRDATA;
        end else begin
          rdata0_q <= apb.PRDATA;
        end
      end
    end
  end

  assign apb.PSEL    = phase.psel;
  assign apb.PENABLE = phase.penable;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb2_master_arbiter.sv
// Directed bench for apb2_master_arbiter with a small memory-backed APB slave.
module tb_apb2_master_arbiter;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;

  logic       req0_valid = 1'b0, req0_write = 1'b0;
  logic [3:0] req0_addr = 4'h0;
  logic [7:0] req0_wdata = 8'h00;
  logic       req0_ready, req0_done;
  logic [7:0] req0_rdata;

  logic       req1_valid = 1'b0, req1_write = 1'b0;
  logic [3:0] req1_addr = 4'h0;
  logic [7:0] req1_wdata = 8'h00;
  logic       req1_ready, req1_done;
  logic [7:0] req1_rdata;

  logic [7:0] mem [16];
  int         wr_count = 0;
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = 4'h0;
  logic [7:0] pre_data = 8'h00;

  int chk_cnt = 0;
  int pass_cnt = 0;

  apb2_master_arbiter_if #(.ADDR_BITS(4), .DATA_BITS(8)) bus ();

  apb2_master_arbiter #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .apb        (bus)
  );

  always #5 PCLK = ~PCLK;

  // Zero-wait-state slave; preload port lets the bench seed read data.
  assign bus.PRDATA = mem[bus.PADDR];
  always @(posedge PCLK) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.PSEL && bus.PENABLE && bus.PWRITE) begin
      mem[bus.PADDR] <= bus.PWDATA;
      wr_count <= wr_count + 1;
    end
  end

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge PCLK);
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    cyc(); pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc(); pre_we = 1'b0;
  endtask

  task automatic test_reset();
    #2 PRESETn = 1'b0;
    req0_valid = 1'b1;
    smp();
    chk_cnt++; if (bus.PSEL !== 1'b0) $display("FAIL rst_psel: got %0h want 0", bus.PSEL); else pass_cnt++;
    chk_cnt++; if (bus.PENABLE !== 1'b0) $display("FAIL rst_penable: got %0h want 0", bus.PENABLE); else pass_cnt++;
    chk_cnt++; if (bus.PWRITE !== 1'b0) $display("FAIL rst_pwrite: got %0h want 0", bus.PWRITE); else pass_cnt++;
    chk_cnt++; if (bus.PADDR !== 4'h0) $display("FAIL rst_paddr: got %0h want 0", bus.PADDR); else pass_cnt++;
    chk_cnt++; if (bus.PWDATA !== 8'h00) $display("FAIL rst_pwdata: got %0h want 0", bus.PWDATA); else pass_cnt++;
    chk_cnt++; if ({req1_done, req0_done} !== 2'b00) $display("FAIL rst_done: got %0b want 00", {req1_done, req0_done}); else pass_cnt++;
    chk_cnt++; if ({req1_rdata, req0_rdata} !== 16'h0) $display("FAIL rst_rdata: got %0h want 0", {req1_rdata, req0_rdata}); else pass_cnt++;
    chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_ready: got %0h want 0", req0_ready); else pass_cnt++;
    cyc(); req0_valid = 1'b0; PRESETn = 1'b1;
    smp();
    chk_cnt++; if (bus.PSEL !== 1'b0) $display("FAIL rel_psel: got %0h want 0", bus.PSEL); else pass_cnt++;
  endtask

  task automatic test_single_write();
    cyc(); req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h3; req0_wdata = 8'hA5;
    smp();
    chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL wr_ready0: got %0h want 1", req0_ready); else pass_cnt++;
    chk_cnt++; if (req1_ready !== 1'b0) $display("FAIL wr_ready1: got %0h want 0", req1_ready); else pass_cnt++;
    chk_cnt++; if (bus.PSEL !== 1'b0) $display("FAIL wr_k_psel: got %0h want 0", bus.PSEL); else pass_cnt++;
    cyc(); req0_valid = 1'b0;
    smp();
    chk_cnt++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) $display("FAIL wr_setup: got %0b want 10", {bus.PSEL, bus.PENABLE}); else pass_cnt++;
    chk_cnt++; if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {1'b1, 4'h3, 8'hA5}) $display("FAIL wr_attr: got %0h want 13a5", {bus.PWRITE, bus.PADDR, bus.PWDATA}); else pass_cnt++;
    cyc(); smp();
    chk_cnt++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) $display("FAIL wr_access: got %0b want 11", {bus.PSEL, bus.PENABLE}); else pass_cnt++;
    chk_cnt++; if (req0_done !== 1'b0) $display("FAIL wr_early_done: got %0h want 0", req0_done); else pass_cnt++;
    cyc(); smp();
    chk_cnt++; if ({req1_done, req0_done} !== 2'b01) $display("FAIL wr_done: got %0b want 01", {req1_done, req0_done}); else pass_cnt++;
    chk_cnt++; if (bus.PSEL !== 1'b0) $display("FAIL wr_idle_psel: got %0h want 0", bus.PSEL); else pass_cnt++;
    chk_cnt++; if (mem[3] !== 8'hA5) $display("FAIL wr_mem3: got %0h want a5", mem[3]); else pass_cnt++;
    cyc(); smp();
    chk_cnt++; if (req0_done !== 1'b0) $display("FAIL wr_done_pulse: got %0h want 0", req0_done); else pass_cnt++;
  endtask

  task automatic test_read();
    preload(4'h6, 8'h5A);
    preload(4'h5, 8'h3C);
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4'h5;
    smp();
    chk_cnt++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL rd_ready: got %0b want 10", {req1_ready, req0_ready}); else pass_cnt++;
    cyc(); req1_valid = 1'b0;
    smp();
    chk_cnt++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b100, 4'h5}) $display("FAIL rd_setup: got %0h want 45", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}); else pass_cnt++;
    cyc(); smp();
    chk_cnt++; if (bus.PENABLE !== 1'b1) $display("FAIL rd_access: got %0h want 1", bus.PENABLE); else pass_cnt++;
    cyc(); smp();
    chk_cnt++; if ({req1_done, req0_done} !== 2'b10) $display("FAIL rd_done: got %0b want 10", {req1_done, req0_done}); else pass_cnt++;
    chk_cnt++; if (req1_rdata !== 8'h3C) $display("FAIL rd_rdata1: got %0h want 3c", req1_rdata); else pass_cnt++;
    chk_cnt++; if (req0_rdata !== 8'h00) $display("FAIL rd_rdata0: got %0h want 0", req0_rdata); else pass_cnt++;
    cyc(); smp();
    chk_cnt++; if ({req1_done, req1_rdata} !== {1'b0, 8'h3C}) $display("FAIL rd_hold: got %0h want 03c", {req1_done, req1_rdata}); else pass_cnt++;
  endtask

  task automatic test_contention();
    int order[$];
    int acc[$];
    int first, last, psel_n, done_n, both_n, n0, n1;
    logic r0, r1;
    first = -1; last = -1; psel_n = 0; done_n = 0; both_n = 0; n0 = 0; n1 = 0;
    cyc(); PRESETn = 1'b0; #2 PRESETn = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h1; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 4'h2; req1_wdata = 8'h22;
    for (int c = 0; c < 12; c++) begin
      smp();
      r0 = req0_ready; r1 = req1_ready;
      if (r0 && r1) both_n++;
      if (r0) begin order.push_back(0); acc.push_back(c); end
      if (r1) begin order.push_back(1); acc.push_back(c); end
      if (bus.PSEL) begin if (first < 0) first = c; last = c; psel_n++; end
      done_n += int'(req0_done) + int'(req1_done);
      cyc();
      if (r0) begin n0++; req0_addr = req0_addr + 4'h2; if (n0 == 2) req0_valid = 1'b0; end
      if (r1) begin n1++; req1_addr = req1_addr + 4'h2; if (n1 == 2) req1_valid = 1'b0; end
    end
    chk_cnt++; if (order.size() != 4) $display("FAIL ct_count: got %0d want 4", order.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i < order.size()) ? order[i] : -1;
      chk_cnt++; if (g != i % 2) $display("FAIL ct_order%0d: got %0d want %0d", i, g, i % 2); else pass_cnt++;
    end
    chk_cnt++; if (acc.size() != 4 || acc[3] - acc[0] != 6) $display("FAIL ct_rate: got %0d accepts want 4 spanning 6 cycles", acc.size()); else pass_cnt++;
    chk_cnt++; if (psel_n != 8 || last - first + 1 != psel_n) $display("FAIL ct_psel: got %0d cycles (%0d..%0d) want 8 contiguous", psel_n, first, last); else pass_cnt++;
    chk_cnt++; if (done_n != 4) $display("FAIL ct_done: got %0d want 4", done_n); else pass_cnt++;
    chk_cnt++; if (both_n != 0) $display("FAIL ct_onehot: got %0d double grants want 0", both_n); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dones[$];
    int wc0, n;
    logic r0;
    n = 0;
    wc0 = wr_count;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h8; req0_wdata = 8'h40;
    for (int c = 0; c < 14; c++) begin
      smp();
      if (req0_done) dones.push_back(c);
      r0 = req0_ready;
      cyc();
      if (r0) begin
        n++; req0_addr = req0_addr + 4'h1; req0_wdata = req0_wdata + 8'h1;
        if (n == 4) req0_valid = 1'b0;
      end
    end
    chk_cnt++; if (dones.size() != 4) $display("FAIL b2b_ndone: got %0d want 4", dones.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = (i < dones.size()) ? dones[i] : -1;
      chk_cnt++; if (d != 3 + 2 * i) $display("FAIL b2b_done%0d: got cycle %0d want %0d", i, d, 3 + 2 * i); else pass_cnt++;
    end
    chk_cnt++; if (wr_count - wc0 != 4) $display("FAIL b2b_writes: got %0d want 4", wr_count - wc0); else pass_cnt++;
    chk_cnt++; if (mem[11] !== 8'h43) $display("FAIL b2b_memb: got %0h want 43", mem[11]); else pass_cnt++;
  endtask

  task automatic test_reset_access();
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4'h6;
    smp();
    chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL ra_ready: got %0h want 1", req1_ready); else pass_cnt++;
    cyc(); req1_valid = 1'b0;
    cyc(); smp();
    chk_cnt++; if (bus.PENABLE !== 1'b1) $display("FAIL ra_access: got %0h want 1", bus.PENABLE); else pass_cnt++;
    #1 PRESETn = 1'b0;
    #1;
    chk_cnt++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) $display("FAIL ra_async: got %0b want 00", {bus.PSEL, bus.PENABLE}); else pass_cnt++;
    cyc(); req1_valid = 1'b1;
    smp();
    chk_cnt++; if ({req1_done, req1_ready, req1_rdata} !== 10'h0) $display("FAIL ra_in_reset: got %0h want 0", {req1_done, req1_ready, req1_rdata}); else pass_cnt++;
    cyc(); PRESETn = 1'b1;
    smp();
    chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL ra_represent: got %0h want 1", req1_ready); else pass_cnt++;
    cyc(); req1_valid = 1'b0;
    smp();
    chk_cnt++; if (req1_done !== 1'b0) $display("FAIL ra_no_done: got %0h want 0", req1_done); else pass_cnt++;
    cyc(); cyc(); smp();
    chk_cnt++; if ({req1_done, req1_rdata} !== {1'b1, 8'h5A}) $display("FAIL ra_complete: got %0h want 15a", {req1_done, req1_rdata}); else pass_cnt++;
  endtask

  task automatic test_idle_hold();
    cyc(); req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 4'hF; req1_wdata = 8'h11;
    smp();
    chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL ih_ready: got %0h want 1", req1_ready); else pass_cnt++;
    cyc(); req1_valid = 1'b0;
    cyc(); cyc(); smp();
    chk_cnt++; if ({req1_done, req1_rdata} !== {1'b1, 8'h5A}) $display("FAIL ih_done_rdata: got %0h want 15a", {req1_done, req1_rdata}); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      chk_cnt++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) $display("FAIL ih_psel%0d: got %0b want 00", i, {bus.PSEL, bus.PENABLE}); else pass_cnt++;
      chk_cnt++; if (bus.PADDR !== 4'hF) $display("FAIL ih_paddr%0d: got %0h want f", i, bus.PADDR); else pass_cnt++;
      chk_cnt++; if (bus.PWDATA !== 8'h11) $display("FAIL ih_pwdata%0d: got %0h want 11", i, bus.PWDATA); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_back_to_back();
    test_reset_access();
    test_idle_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb2_master_arbiter.md
APB2_MASTER_ARBITER -- requirements
Module: apb2_master_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 4, SHALL set the width of the APB address and both requester address ports.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the width of the APB data buses and both requester data ports.
REQ-003 PCLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 PRESETn  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1): requester N has a transfer pending; held until accepted.
REQ-006 reqN_write  input  1: 1 = write, 0 = read; sampled on acceptance.
REQ-007 reqN_addr  input  ADDR_BITS: transfer address; sampled on acceptance.
REQ-008 reqN_wdata  input  DATA_BITS: write data; sampled on acceptance.
REQ-009 reqN_ready  output  1: combinational accept strobe for requester N.
REQ-010 reqN_done  output  1: one-cycle registered completion pulse for requester N.
REQ-011 reqN_rdata  output  DATA_BITS: read data, valid while reqN_done=1 for a read.
REQ-012 PADDR  output  ADDR_BITS: APB2 address.
REQ-013 PSEL  output  1: APB2 select.
REQ-014 PENABLE  output  1: APB2 enable.
REQ-015 PWRITE  output  1: APB2 direction.
REQ-016 PWDATA  output  DATA_BITS: APB2 write data.
REQ-017 PRDATA  input  DATA_BITS: APB2 read data from the slave.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE (PSEL=0, PENABLE=0), SETUP (PSEL=1, PENABLE=0) and ACCESS (PSEL=1, PENABLE=1).
REQ-019 Acceptance SHALL be possible only in IDLE or ACCESS; at most one reqN_ready SHALL be high per cycle, and only when the matching reqN_valid=1.
REQ-020 On the accepting edge, the block SHALL register reqN_write, reqN_addr and reqN_wdata into PWRITE, PADDR and PWDATA, and the FSM SHALL enter SETUP.
REQ-021 SETUP SHALL always last exactly one cycle and be followed by ACCESS; APB2 has no wait states.
REQ-022 At the edge ending ACCESS, the block SHALL capture PRDATA into the granted requester's reqN_rdata (reads only) and assert reqN_done for the following cycle.
REQ-023 Latency: with acceptance in cycle k, SETUP SHALL occur in k+1, ACCESS in k+2, and done in k+3.
REQ-024 An acceptance during ACCESS SHALL go directly to SETUP (PSEL stays 1); with no acceptance, the FSM SHALL return to IDLE. Sustained throughput SHALL be one transfer per 2 cycles.
REQ-025 Arbitration SHALL be round-robin: if both requesters are valid, grant the requester not granted last; if only one is valid, grant it regardless of history.
REQ-026 The last-grant pointer SHALL update only on acceptance and SHALL reset to 1, so requester 0 wins the first contention.
REQ-027 In IDLE, PADDR, PWRITE and PWDATA SHALL hold their last values; PSEL and PENABLE SHALL be 0.
REQ-028 reqN_rdata SHALL hold its value between reads; after a write it SHALL be unchanged.
REQ-029 If done for one transfer coincides with acceptance of another, both SHALL occur in the same cycle.

Reset
REQ-030 Asserting PRESETn=0 SHALL immediately force the FSM to IDLE and all outputs to 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, reqN_done, reqN_rdata); reqN_ready SHALL be 0 while in reset.
REQ-031 A reset during SETUP or ACCESS SHALL abort the transfer with no reqN_done pulse, and the requester SHALL re-present its request.

Structure
REQ-032 A shared package apb2_pkg SHALL hold the FSM state encoding constants (IDLE, SETUP, ACCESS) and the APB2 phase constants.
REQ-033 Round-robin selection SHALL be one sub-module, rr_arbiter2 (inputs: two valids and the last-grant pointer; outputs: grant index and grant-valid).

Verification
REQ-034 Single write: req0 write addr=0x3 wdata=0xA5 -> PSEL high k+1, PENABLE high k+2, slave mem[3]=0xA5, req0_done=1 at k+3.
REQ-035 Read: slave mem[5]=0x3C, req1 read addr=0x5 -> req1_rdata=0x3C with req1_done at k+3; req0_done stays 0.
REQ-036 Contention: both valid from reset -> req0 accepted first, req1 accepted during req0's ACCESS, SETUP follows directly with PSEL never dropping; order 0,1,0,1 over 4 transfers.
REQ-037 Back-to-back: req0 valid for 4 writes -> done pulses at k+3, k+5, k+7, k+9 and the slave write count is 4.
REQ-038 Reset in ACCESS: PRESETn=0 mid-read -> PSEL=PENABLE=0 asynchronously, no done pulse; after release, the re-presented request completes normally.
REQ-039 Idle hold: after a write to 0xF/0x11 -> in IDLE, PADDR=0xF and PWDATA=0x11 hold with PSEL=0 for at least 5 cycles.
